// File: rtl/lstm_gate_scheduler_if.sv
// Operand and pre-activation streams of the LSTM gate scheduler.
// Both streams transfer on a rising clk edge where valid && ready; valid never waits on ready, and the sender holds its data stable until that edge.
interface lstm_gate_scheduler_if #(
    parameter int DATA_WIDTH = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   in_x;
    logic [DATA_WIDTH-1:0]   in_h;
    logic [4*DATA_WIDTH-1:0] in_w;
    logic [4*DATA_WIDTH-1:0] in_u;
    logic [4*DATA_WIDTH-1:0] in_b;
    logic [4*DATA_WIDTH-1:0] out_gates;
    logic                    out_valid;
    logic                    out_ready;

    // The environment side: operand fetch upstream, activation stage downstream.
    modport master (
        output in_valid, in_x, in_h, in_w, in_u, in_b, out_ready,
        input  in_ready, out_gates, out_valid
    );

    // The scheduler side.
    modport slave (
        input  in_valid, in_x, in_h, in_w, in_u, in_b, out_ready,
        output in_ready, out_gates, out_valid
    );
endinterface

// File: rtl/lstm_gate_scheduler.sv
// Shares one combinational W*x + U*h + b unit across the i/f/o/g gates of each element
// and hands the four pre-activations downstream, element by element, for a run of len.
module lstm_gate_scheduler #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRACT_WIDTH = 8,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  len,
    lstm_gate_scheduler_if.slave  io,
    output logic [DATA_WIDTH-1:0] mac_w,
    output logic [DATA_WIDTH-1:0] mac_x,
    output logic [DATA_WIDTH-1:0] mac_u,
    output logic [DATA_WIDTH-1:0] mac_h,
    output logic [DATA_WIDTH-1:0] mac_b,
    input  logic [DATA_WIDTH-1:0] mac_out,
    output logic [1:0]            gate_sel,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            state_dbg
);

    // FRACT_WIDTH only describes the MAC's Q-format; a format without integer bits is meaningless.
    if (FRACT_WIDTH >= DATA_WIDTH) begin : g_fract_out_of_range
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_GATE,
        S_OUT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [CNT_WIDTH-1:0]    len_q;
    logic [CNT_WIDTH-1:0]    cnt;
    logic [DATA_WIDTH-1:0]   x_q, h_q;
    logic [4*DATA_WIDTH-1:0] w_q, u_q, b_q;
    logic                    in_fire;
    logic                    out_fire;
    logic                    last_elem;

    assign in_fire   = io.in_valid && (state == S_LOAD);
    assign out_fire  = io.out_ready && (state == S_OUT);
    // One extra bit so len = 2^CNT_WIDTH-1 compares before the count could wrap.
    assign last_elem = ({1'b0, cnt} + (CNT_WIDTH+1)'(1)) == {1'b0, len_q};
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        io.in_ready  = 1'b0;
        io.out_valid = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        mac_w        = '0;
        mac_x        = '0;
        mac_u        = '0;
        mac_h        = '0;
        mac_b        = '0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (len != '0) ? S_LOAD : S_DONE;
                end
            end
            S_LOAD: begin
                io.in_ready = 1'b1;
                if (io.in_valid) begin
                    state_nxt = S_GATE;
                end
            end
            S_GATE: begin
                mac_w = w_q[int'(gate_sel)*DATA_WIDTH +: DATA_WIDTH];
                mac_u = u_q[int'(gate_sel)*DATA_WIDTH +: DATA_WIDTH];
                mac_b = b_q[int'(gate_sel)*DATA_WIDTH +: DATA_WIDTH];
                mac_x = x_q;
                mac_h = h_q;
                if (gate_sel == 2'd3) begin
                    state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                io.out_valid = 1'b1;
                if (io.out_ready) begin
                    state_nxt = last_elem ? S_DONE : S_LOAD;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q        <= '0;
            cnt          <= '0;
            x_q          <= '0;
            h_q          <= '0;
            w_q          <= '0;
            u_q          <= '0;
            b_q          <= '0;
            gate_sel     <= '0;
            io.out_gates <= '0;
        end else begin
            if (state == S_IDLE && start && len != '0) begin
                len_q <= len;
                cnt   <= '0;
            end
            if (in_fire) begin
                x_q      <= io.in_x;
                h_q      <= io.in_h;
                w_q      <= io.in_w;
                u_q      <= io.in_u;
                b_q      <= io.in_b;
                gate_sel <= '0;
            end
            // gate_sel wraps 3 -> 0 on the last gate, so it reads 0 outside the gate phase.
            if (state == S_GATE) begin
                io.out_gates[int'(gate_sel)*DATA_WIDTH +: DATA_WIDTH] <= mac_out;
                gate_sel <= gate_sel + 2'd1;
            end
            if (out_fire) begin
                cnt <= cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule
